// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter in front of a single unified memory_unit.
// Define MEM_ARB_FIXED_PRIO_EN for fixed data-over-fetch priority; default is round-robin.
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic       OWN_F    = 1'b0;
  localparam logic       OWN_D    = 1'b1;
  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT);

  state_t              state_q;
  state_t              state_d;
  logic                owner_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   f_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic [2:0]          cnt_q;
  logic                grant_f;
  logic                grant_d;
  logic                take;

  assign take = (state_q == IDLE) && (grant_f || grant_d);

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Data always wins a tie; fetch only proceeds when data is not requesting.
  always_comb begin
    grant_d = d_req;
    grant_f = f_req & ~d_req;
  end
`else
  logic last_grant_q;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    grant_f = f_req & (~d_req | (last_grant_q == OWN_D));
    grant_d = d_req & ~grant_f;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      last_grant_q <= OWN_D;
    end else if (take) begin
      last_grant_q <= grant_d ? OWN_D : OWN_F;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_f || grant_d) state_d = ISSUE;
      ISSUE:   state_d = we_q ? RESP : WAIT;
      WAIT:    if (cnt_q == 3'd1) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request inputs are captured once at grant so later changes cannot disturb the access.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      owner_q <= OWN_F;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (take) begin
      if (grant_d) begin
        owner_q <= OWN_D;
        we_q    <= d_we;
        addr_q  <= d_addr;
        wdata_q <= d_wdata;
      end else begin
        owner_q <= OWN_F;
        we_q    <= 1'b0;
        addr_q  <= f_addr;
        wdata_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      cnt_q <= LAT_LOAD;
    end else if (state_q == WAIT) begin
      cnt_q <= cnt_q - 3'd1;
    end
  end

  // Read data is taken on the edge that closes the final WAIT cycle.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if ((state_q == WAIT) && (cnt_q == 3'd1)) begin
      if (owner_q == OWN_D) begin
        d_rdata_q <= mem_data_out;
      end else begin
        f_rdata_q <= mem_data_out;
      end
    end
  end

  assign mem_en      = (state_q == ISSUE) || (state_q == WAIT);
  assign mem_wen     = (state_q == ISSUE) && we_q;
  assign mem_addr    = addr_q;
  assign mem_data_in = wdata_q;
  assign busy        = (state_q != IDLE);
  assign f_ack       = (state_q == RESP) && (owner_q == OWN_F);
  assign d_ack       = (state_q == RESP) && (owner_q == OWN_D);
  assign f_rdata     = f_rdata_q;
  assign d_rdata     = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: RD_LAT=1 instance with scoreboard, plus an RD_LAT=3 instance.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic clr_n;

  logic          f_req, d_req, d_we, f_ack, d_ack, mem_en, mem_wen, busy;
  logic [AW-1:0] f_addr, d_addr, mem_addr;
  logic [DW-1:0] d_wdata, f_rdata, d_rdata, mem_data_in, mem_data_out;

  logic          f_req_b, d_req_b, d_we_b, f_ack_b, d_ack_b, mem_en_b, mem_wen_b, busy_b;
  logic [AW-1:0] f_addr_b, d_addr_b, mem_addr_b;
  logic [DW-1:0] d_wdata_b, f_rdata_b, d_rdata_b, mem_data_in_b, mem_data_out_b;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
    .clk(clk), .clr_n(clr_n),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut_b (
    .clk(clk), .clr_n(clr_n),
    .f_req(f_req_b), .f_addr(f_addr_b), .f_ack(f_ack_b), .f_rdata(f_rdata_b),
    .d_req(d_req_b), .d_we(d_we_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
    .d_ack(d_ack_b), .d_rdata(d_rdata_b),
    .mem_en(mem_en_b), .mem_wen(mem_wen_b), .mem_addr(mem_addr_b),
    .mem_data_in(mem_data_in_b), .mem_data_out(mem_data_out_b), .busy(busy_b)
  );

  // Memory models with backdoor load port and fixed read latency
  logic          bk_we, bk_sel;
  logic [AW-1:0] bk_addr;
  logic [DW-1:0] bk_data;
  logic [DW-1:0] mem_a [0:255];
  logic [DW-1:0] mem_b [0:255];
  logic [DW-1:0] pipe_a;
  logic [DW-1:0] pipe_b [0:2];

  always @(posedge clk) begin
    if (bk_we && !bk_sel) mem_a[bk_addr] <= bk_data;
    else if (mem_en && mem_wen) mem_a[mem_addr] <= mem_data_in;
    pipe_a <= mem_a[mem_addr];
  end
  assign mem_data_out = pipe_a;

  always @(posedge clk) begin
    if (bk_we && bk_sel) mem_b[bk_addr] <= bk_data;
    else if (mem_en_b && mem_wen_b) mem_b[mem_addr_b] <= mem_data_in_b;
    pipe_b[0] <= mem_b[mem_addr_b];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign mem_data_out_b = pipe_b[2];

  typedef struct {
    bit            dside;
    logic [DW-1:0] data;
    bit            chk;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;
  logic [DW-1:0] mon_rd;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic push(input bit dside, input logic [DW-1:0] data, input bit chk);
    exp_t e;
    e.dside = dside; e.data = data; e.chk = chk;
    sb_q.push_back(e);
  endtask

  task automatic bk_write(input bit sel, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    bk_we = 1'b1; bk_sel = sel; bk_addr = a; bk_data = d;
    @(negedge clk);
    bk_we = 1'b0;
  endtask

  // Scoreboard: every ack pops the oldest expectation and checks owner and data
  always @(negedge clk) begin
    if (clr_n && (f_ack || d_ack)) begin
      n_cmp++;
      assert ((sb_q.size() != 0) && !(f_ack && d_ack)) else begin
        n_err++;
        $error("FAIL sb_ack f_ack=%0b d_ack=%0b queued=%0d expected one ack with queued entry",
               f_ack, d_ack, sb_q.size());
      end
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        n_cmp++;
        assert (d_ack === mon_e.dside) else begin
          n_err++;
          $error("FAIL sb_owner observed d_ack=%0b expected=%0b", d_ack, mon_e.dside);
        end
        if (mon_e.chk) begin
          mon_rd = d_ack ? d_rdata : f_rdata;
          n_cmp++;
          assert (mon_rd === mon_e.data) else begin
            n_err++;
            $error("FAIL sb_rdata observed=%0h expected=%0h", mon_rd, mon_e.data);
          end
        end
      end
    end
  end

  // Caller raises the request at a negedge while the arbiter is idle
  task automatic run_a(input bit dside, input int exp_lat, input logic [AW-1:0] exp_addr,
                       input bit exp_we, input bit chg);
    int k = 0, en_n = 0, wen_n = 0, bad_addr = 0, wrong_ack = 0;
    bit got = 1'b0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        check("busy_after_grant", busy, 1);
        if (chg) d_addr = d_addr + 8'd1;
      end
      if (mem_en) begin
        en_n++;
        if (mem_addr !== exp_addr) bad_addr++;
      end
      if (mem_wen) wen_n++;
      if (dside ? f_ack : d_ack) wrong_ack++;
      if (dside ? d_ack : f_ack) got = 1'b1;
    end
    if (dside) d_req = 1'b0; else f_req = 1'b0;
    check("ack_latency", k, exp_lat);
    check("mem_en_cycles", en_n, exp_lat - 1);
    check("mem_wen_cycles", wen_n, exp_we);
    check("mem_addr_stable", bad_addr, 0);
    check("other_ack_low", wrong_ack, 0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic f_thread(input int n, input logic [AW-1:0] base);
    for (int i = 0; i < n; i++) begin
      int t;
      t = 0;
      f_addr = base + 8'(i);
      f_req = 1'b1;
      do begin @(negedge clk); t++; end while (!f_ack && t < 60);
      check("f_thread_ack", f_ack, 1);
      f_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic d_thread(input int n, input logic [AW-1:0] base);
    for (int i = 0; i < n; i++) begin
      int t;
      t = 0;
      d_we = 1'b0;
      d_addr = base + 8'(i);
      d_req = 1'b1;
      do begin @(negedge clk); t++; end while (!d_ack && t < 60);
      check("d_thread_ack", d_ack, 1);
      d_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, en_n, bad_addr, wrong_ack;
    f_req = 0; f_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    f_req_b = 0; f_addr_b = '0; d_req_b = 0; d_we_b = 0; d_addr_b = '0; d_wdata_b = '0;
    bk_we = 0; bk_sel = 0; bk_addr = '0; bk_data = '0;
    clr_n = 1'b1;
    #2 clr_n = 1'b0;

    bk_write(0, 8'h04, 32'hDEADBEEF);
    bk_write(0, 8'h11, 32'hBADC0FFE);
    bk_write(0, 8'h40, 32'hF0000040);
    bk_write(0, 8'h41, 32'hF0000041);
    bk_write(0, 8'h42, 32'hF0000042);
    bk_write(0, 8'h43, 32'hF0000043);
    bk_write(0, 8'h50, 32'hD0000050);
    bk_write(0, 8'h51, 32'hD0000051);
    bk_write(0, 8'h52, 32'hD0000052);
    bk_write(1, 8'h20, 32'h000000A5);

    check("rst_busy", busy, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_acks", {f_ack, d_ack, mem_wen}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_b_busy_en", {busy_b, mem_en_b}, 0);

    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Fetch read of word 4
    push(0, 32'hDEADBEEF, 1);
    f_addr = 8'h04; f_req = 1'b1;
    run_a(0, 3, 8'h04, 0, 0);

    // Data write, then read back
    push(1, '0, 0);
    d_we = 1'b1; d_addr = 8'h10; d_wdata = 32'h12345678; d_req = 1'b1;
    run_a(1, 2, 8'h10, 1, 0);
    push(1, 32'h12345678, 1);
    d_we = 1'b0; d_addr = 8'h10; d_req = 1'b1;
    run_a(1, 3, 8'h10, 0, 0);

    // Address changes after grant must be ignored
    push(1, 32'h12345678, 1);
    d_we = 1'b0; d_addr = 8'h10; d_req = 1'b1;
    run_a(1, 3, 8'h10, 0, 1);

    // Simultaneous requests from reset-state arbitration history
`ifdef MEM_ARB_FIXED_PRIO_EN
    push(1, 32'hD0000050, 1); push(0, 32'hF0000040, 1);
    push(1, 32'hD0000051, 1); push(0, 32'hF0000041, 1);
`else
    push(0, 32'hF0000040, 1); push(1, 32'hD0000050, 1);
    push(0, 32'hF0000041, 1); push(1, 32'hD0000051, 1);
`endif
    fork
      f_thread(2, 8'h40);
      d_thread(2, 8'h50);
    join

    // Lone fetch makes fetch the last grant; the next tie goes to data
    push(0, 32'hF0000042, 1);
    f_addr = 8'h42; f_req = 1'b1;
    run_a(0, 3, 8'h42, 0, 0);
    push(1, 32'hD0000052, 1); push(0, 32'hF0000043, 1);
    fork
      f_thread(1, 8'h43);
      d_thread(1, 8'h52);
    join

    // RD_LAT=3 instance: data read of 0x20
    d_we_b = 1'b0; d_addr_b = 8'h20; d_req_b = 1'b1;
    k = 0; en_n = 0; bad_addr = 0; wrong_ack = 0;
    while (!d_ack_b && k < 20) begin
      @(negedge clk);
      k++;
      if (mem_en_b) begin
        en_n++;
        if (mem_addr_b !== 8'h20) bad_addr++;
      end
      if (f_ack_b) wrong_ack++;
    end
    check("b_ack_latency", k, 5);
    check("b_rdata", d_rdata_b, 32'h000000A5);
    d_req_b = 1'b0;
    check("b_mem_en_cycles", en_n, 4);
    check("b_addr_stable", bad_addr, 0);
    check("b_f_ack_low", wrong_ack, 0);
    @(negedge clk);
    @(negedge clk);

    // Reset during the WAIT of a fetch aborts it
    push(0, 32'hDEADBEEF, 1);
    f_addr = 8'h04; f_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_wait_mem_en", mem_en, 1);
    clr_n = 1'b0;
    #1;
    check("abort_ctrl_outs", {f_ack, d_ack, mem_en, mem_wen, busy}, 0);
    check("abort_mem_addr", mem_addr, 0);
    check("abort_mem_data_in", mem_data_in, 0);
    check("abort_rdata", {f_rdata, d_rdata}, 0);
    void'(sb_q.pop_front());
    f_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    wrong_ack = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (f_ack || d_ack || busy) wrong_ack++;
    end
    check("no_ack_after_abort", wrong_ack, 0);
    push(0, 32'hDEADBEEF, 1);
    f_addr = 8'h04; f_req = 1'b1;
    run_a(0, 3, 8'h04, 0, 0);

    check("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter sharing one memory_unit instance between instruction fetch and data load/store traffic.
- Target use: a multi-cycle variant of the processor with a single unified memory.
- Sequences each access through a request/ack handshake.
- Drives the memory's en/wen/addr/data_in pins and returns read data to the winning requester.

Parameters:
- ADDR_W, 8, memory word-address width.
- DATA_W, 32, data bus width.
- RD_LAT, 1, memory read latency in cycles; legal range 1..4.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- clr_n  in  1  reset, asynchronous, active-low.
- f_req  in  1  fetch request; level, held until f_ack.
- f_addr  in  ADDR_W  fetch address.
- f_ack  out  1  single-cycle fetch completion pulse.
- f_rdata  out  DATA_W  fetch read data; valid while f_ack=1.
- d_req  in  1  data request; level, held until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_ack  out  1  single-cycle data completion pulse.
- d_rdata  out  DATA_W  data read data; valid while d_ack=1.
- mem_en  out  1  memory chip enable.
- mem_wen  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_data_in  out  DATA_W  memory write data.
- mem_data_out  in  DATA_W  memory read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (clr_n=0, asynchronous):
  - state=IDLE; last_grant=DATA.
  - All outputs 0; latched address, data and owner cleared.
- Reset mid-transaction aborts the access with no ack; requesters must re-request.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Only one request: grant it.
  - Both requesting: grant the requester that is not last_grant (round-robin).
  - On grant, at the edge:
    - latch owner, addr, we (fetch forces we=0) and wdata;
    - update last_grant;
    - go to ISSUE.
- ISSUE (1 cycle):
  - mem_en=1, mem_addr=latched addr, mem_data_in=latched wdata, mem_wen=latched we.
  - Next state: RESP if we=1, else WAIT with counter loaded to RD_LAT.
- WAIT (RD_LAT cycles):
  - mem_en=1, mem_wen=0, address held stable.
  - Counter decrements each cycle.
  - At the edge ending the last WAIT cycle: capture mem_data_out into the owner's rdata register and go to RESP.
- RESP (1 cycle):
  - Owner's ack=1, rdata stable; mem_en=0.
  - Next state is IDLE unconditionally.
- Latency from the IDLE edge that grants to the ack cycle:
  - write: 2 cycles;
  - read: 2+RD_LAT cycles.
- Handshake rules:
  - The requester must hold req, addr, we and wdata until ack.
  - req must be low in the cycle after ack; the arbiter samples req only in IDLE.
  - Request inputs that change after the grant are ignored (values are latched).
- f_rdata and d_rdata hold their last captured value after ack. They are defined only during ack.
- ack is never asserted to a requester that does not own the transaction. f_ack and d_ack are never high together.
- Requests arriving while busy=1 wait in IDLE. No queue depth beyond one pending request per requester.
- Maximum wait for a continuously asserted request under round-robin: one full competing transaction.

Optional Feature:
- Macro MEM_ARB_FIXED_PRIO_EN.
- Defined:
  - data requester always wins ties;
  - last_grant is unused;
  - fetch may starve under continuous d_req.
- Undefined: round-robin tie-break as described in Behaviour.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then f_req=1, f_addr=8'h04, memory word 4 = 32'hDEADBEEF, RD_LAT=1 -> busy rises; mem_en=1, mem_wen=0, mem_addr=8'h04 for 2 cycles; f_ack pulse on cycle 3 after grant; f_rdata=32'hDEADBEEF; d_ack stays 0.
- d_req=1, d_we=1, d_addr=8'h10, d_wdata=32'h12345678 -> mem_wen=1 for exactly 1 cycle; d_ack 2 cycles after grant; subsequent data read of 8'h10 returns 32'h12345678.
- f_req and d_req raised in the same cycle after reset -> fetch granted first, then data. With both held continuously, grants alternate F, D, F, D. With MEM_ARB_FIXED_PRIO_EN defined, data is granted first and fetch waits until d_req drops.
- RD_LAT=3, read of 8'h20 holding 32'h0000_00A5 -> WAIT lasts 3 cycles; ack 5 cycles after grant with rdata=32'h000000A5; mem_addr stable throughout.
- clr_n pulsed low during WAIT of a fetch -> all outputs 0 immediately; no f_ack; after release and re-request, the fetch completes normally.
- d_addr changed from 8'h10 to 8'h11 in the cycle after grant -> mem_addr stays 8'h10; returned data comes from word 8'h10.
